// File: rtl/kamikaze_ahb_pkg.sv
// kamikaze_ahb_pkg
//  Shared AHB-Lite encodings for the kamikaze core bus interface.
//  HTRANS/HSIZE/HPROT constants and the requester owner encoding
//  used by the I/D arbiter.
package kamikaze_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic [3:0] HPROT_INSN = 4'b0000;
  localparam logic [3:0] HPROT_DATA = 4'b0001;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/kamikaze_ahb_arbiter.sv
// kamikaze_ahb_arbiter
//  Shares one AHB-Lite master port between the instruction-fetch (I) and
//  load/store (D) requesters. Each req/gnt/rvalid handshake becomes a
//  pipelined NONSEQ single transfer; responses are routed to whichever side
//  owns the data phase. D has priority, but after MAX_D_RUN consecutive D
//  grants with I waiting, the next grant goes to I.
//
//  Ports
//   clk_i, rst_i                     clock, synchronous active-high reset
//   i_req_i/i_addr_i                 I request (word reads only)
//   i_gnt_o/i_rvalid_o/i_rdata_o/i_err_o   I handshake outputs
//   d_req_i/d_addr_i/d_we_i/d_size_i/d_wdata_i   D request
//   d_gnt_o/d_rvalid_o/d_rdata_o/d_err_o   D handshake outputs
//   HADDR..HPROT                     AHB-Lite master address/control/wdata
//   HRDATA/HREADY/HRESP              AHB-Lite slave response
module kamikaze_ahb_arbiter
  import kamikaze_ahb_pkg::*;
#(
  parameter int MAX_D_RUN = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_req_i,
  input  logic [31:0] i_addr_i,
  output logic        i_gnt_o,
  output logic        i_rvalid_o,
  output logic [31:0] i_rdata_o,
  output logic        i_err_o,
  input  logic        d_req_i,
  input  logic [31:0] d_addr_i,
  input  logic        d_we_i,
  input  logic [2:0]  d_size_i,
  input  logic [31:0] d_wdata_i,
  output logic        d_gnt_o,
  output logic        d_rvalid_o,
  output logic [31:0] d_rdata_o,
  output logic        d_err_o,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  output logic [2:0]  HBURST,
  output logic        HMASTLOCK,
  output logic [3:0]  HPROT,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP
);

  localparam int CNT_W = $clog2(MAX_D_RUN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_D_RUN);

  logic             hold_q;
  owner_e           hold_owner_q;
  logic             dph_valid_q;
  owner_e           dph_owner_q;
  logic             dph_we_q;
  logic [31:0]      wdata_q;
  logic [CNT_W-1:0] run_cnt_q;
  logic             err_q;       // second cycle of a two-cycle ERROR response

  logic   err_first;
  logic   force_idle;
  logic   sel_valid;
  owner_e sel_owner;
  logic   any_gnt;

  // First ERROR cycle is recognised only while a data phase is outstanding.
  assign err_first  = dph_valid_q & HRESP & ~HREADY;
  // The bus must stay IDLE across both ERROR cycles and while reset is held.
  assign force_idle = err_first | err_q | rst_i;

  always_comb begin
    sel_valid = 1'b0;
    sel_owner = OWN_I;
    if (hold_q) begin
      // A stalled address phase keeps its owner regardless of new requests.
      sel_valid = 1'b1;
      sel_owner = hold_owner_q;
    end else if (d_req_i && ((run_cnt_q < CNT_MAX) || !i_req_i)) begin
      sel_valid = 1'b1;
      sel_owner = OWN_D;
    end else if (i_req_i) begin
      sel_valid = 1'b1;
      sel_owner = OWN_I;
    end
    if (force_idle) begin
      sel_valid = 1'b0;
    end
  end

  always_comb begin
    HTRANS = HTRANS_IDLE;
    HADDR  = 32'h0;
    HWRITE = 1'b0;
    HSIZE  = HSIZE_WORD;
    HPROT  = HPROT_INSN;
    if (sel_valid) begin
      HTRANS = HTRANS_NONSEQ;
      if (sel_owner == OWN_D) begin
        HADDR  = d_addr_i;
        HWRITE = d_we_i;
        HSIZE  = d_size_i;
        HPROT  = HPROT_DATA;
      end else begin
        HADDR  = i_addr_i;
      end
    end
  end

  assign HBURST    = 3'b000;
  assign HMASTLOCK = 1'b0;

  assign i_gnt_o = sel_valid & (sel_owner == OWN_I) & HREADY;
  assign d_gnt_o = sel_valid & (sel_owner == OWN_D) & HREADY;
  assign any_gnt = i_gnt_o | d_gnt_o;

  assign i_rvalid_o = dph_valid_q & (dph_owner_q == OWN_I) & HREADY & ~rst_i;
  assign d_rvalid_o = dph_valid_q & (dph_owner_q == OWN_D) & HREADY & ~rst_i;
  assign i_rdata_o  = HRDATA;
  assign d_rdata_o  = HRDATA;
  assign i_err_o    = i_rvalid_o & HRESP;
  assign d_err_o    = d_rvalid_o & HRESP;

  assign HWDATA = (dph_valid_q && dph_owner_q == OWN_D && dph_we_q) ? wdata_q : 32'h0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q       <= 1'b0;
      hold_owner_q <= OWN_I;
      dph_valid_q  <= 1'b0;
      dph_owner_q  <= OWN_I;
      dph_we_q     <= 1'b0;
      wdata_q      <= 32'h0;
      run_cnt_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      err_q <= err_first;

      // Address hold: latch the owner when a NONSEQ stalls; an ERROR
      // response abandons the hold so the request is re-arbitrated.
      if (force_idle) begin
        hold_q <= 1'b0;
      end else if (sel_valid && !HREADY) begin
        hold_q       <= 1'b1;
        hold_owner_q <= sel_owner;
      end else if (HREADY) begin
        hold_q <= 1'b0;
      end

      // Data phase tracking.
      if (any_gnt) begin
        dph_valid_q <= 1'b1;
        dph_owner_q <= sel_owner;
        dph_we_q    <= (sel_owner == OWN_D) & d_we_i;
        if (d_gnt_o) begin
          wdata_q <= d_wdata_i;
        end
      end else if (HREADY) begin
        dph_valid_q <= 1'b0;
      end

      // Starvation counter: counts D grants that overtook a waiting I.
      if (!i_req_i || i_gnt_o) begin
        run_cnt_q <= '0;
      end else if (d_gnt_o && run_cnt_q < CNT_MAX) begin
        run_cnt_q <= run_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_kamikaze_ahb_arbiter.sv
// Directed testbench for kamikaze_ahb_arbiter. Inputs change 1 time unit
// after the rising edge; combinational outputs are checked 1 unit later.
module tb_kamikaze_ahb_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        i_req_i;
  logic [31:0] i_addr_i;
  logic        i_gnt_o, i_rvalid_o, i_err_o;
  logic [31:0] i_rdata_o;
  logic        d_req_i;
  logic [31:0] d_addr_i;
  logic        d_we_i;
  logic [2:0]  d_size_i;
  logic [31:0] d_wdata_i;
  logic        d_gnt_o, d_rvalid_o, d_err_o;
  logic [31:0] d_rdata_o;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;

  int n_checks = 0;
  int n_pass   = 0;

  kamikaze_ahb_arbiter #(.MAX_D_RUN(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_gnt_o(i_gnt_o),
    .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o), .i_err_o(i_err_o),
    .d_req_i(d_req_i), .d_addr_i(d_addr_i), .d_we_i(d_we_i),
    .d_size_i(d_size_i), .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o),
    .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // Advance to 1 unit after the next rising edge.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Expected grant pattern while D and I both request continuously: 1 = D.
  logic [5:0] d_first_pat;

  initial begin
    rst_i = 1'b1; i_req_i = 1'b0; i_addr_i = '0; d_req_i = 1'b0; d_addr_i = '0;
    d_we_i = 1'b0; d_size_i = 3'b010; d_wdata_i = '0;
    HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    cyc(); cyc();
    #1;
    chk("rst_htrans", 32'(HTRANS), 32'h0);
    chk("rst_gnts", {30'h0, i_gnt_o, d_gnt_o}, 32'h0);
    chk("rst_rvalids", {30'h0, i_rvalid_o, d_rvalid_o}, 32'h0);
    chk("rst_hwdata", HWDATA, 32'h0);
    rst_i = 1'b0;

    // 1: I-only back-to-back reads
    cyc();
    i_req_i = 1'b1; i_addr_i = 32'h100; #1;
    chk("t1_c0_htrans", 32'(HTRANS), 32'h2);
    chk("t1_c0_haddr", HADDR, 32'h100);
    chk("t1_c0_ctl", {20'h0, HWRITE, HSIZE, HPROT, HBURST, HMASTLOCK}, {20'h0, 1'b0, 3'b010, 4'b0000, 3'b000, 1'b0});
    chk("t1_c0_gnt", {30'h0, i_gnt_o, d_gnt_o}, 32'h2);
    chk("t1_c0_rvalid", 32'(i_rvalid_o), 32'h0);
    cyc();
    i_addr_i = 32'h104; HRDATA = 32'h1111_0001; #1;
    chk("t1_c1_gnt", 32'(i_gnt_o), 32'h1);
    chk("t1_c1_haddr", HADDR, 32'h104);
    chk("t1_c1_rvalid", 32'(i_rvalid_o), 32'h1);
    chk("t1_c1_rdata", i_rdata_o, 32'h1111_0001);
    cyc();
    i_req_i = 1'b0; HRDATA = 32'h2222_0002; #1;
    chk("t1_c2_htrans", 32'(HTRANS), 32'h0);
    chk("t1_c2_haddr", HADDR, 32'h0);
    chk("t1_c2_rvalid", 32'(i_rvalid_o), 32'h1);
    chk("t1_c2_rdata", i_rdata_o, 32'h2222_0002);
    cyc(); #1;
    chk("t1_c3_rvalid", 32'(i_rvalid_o), 32'h0);

    // 2: simultaneous I and D, D write wins
    cyc();
    i_req_i = 1'b1; i_addr_i = 32'h200;
    d_req_i = 1'b1; d_addr_i = 32'h2000; d_we_i = 1'b1; d_size_i = 3'b010;
    d_wdata_i = 32'hA5A5_0000; #1;
    chk("t2_c0_gnt", {30'h0, i_gnt_o, d_gnt_o}, 32'h1);
    chk("t2_c0_haddr", HADDR, 32'h2000);
    chk("t2_c0_hwrite", {28'h0, HWRITE, HPROT[2:0]}, {28'h0, 1'b1, 3'b001});
    cyc();
    d_req_i = 1'b0; d_we_i = 1'b0; d_wdata_i = 32'h0; #1;
    chk("t2_c1_hwdata", HWDATA, 32'hA5A5_0000);
    chk("t2_c1_gnt", {30'h0, i_gnt_o, d_gnt_o}, 32'h2);
    chk("t2_c1_haddr", HADDR, 32'h200);
    chk("t2_c1_drvalid", {30'h0, d_rvalid_o, d_err_o}, 32'h2);
    cyc();
    i_req_i = 1'b0; #1;
    chk("t2_c2_irvalid", 32'(i_rvalid_o), 32'h1);
    chk("t2_c2_hwdata", HWDATA, 32'h0);
    cyc();

    // 3: anti-starvation, grant pattern D,D,D,D,I,D
    cyc();
    d_first_pat = 6'b101111;
    i_req_i = 1'b1; i_addr_i = 32'h400; d_req_i = 1'b1; d_addr_i = 32'h3000; #1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t3_g%0d", k), {30'h0, d_gnt_o, i_gnt_o},
          d_first_pat[k] ? 32'h2 : 32'h1);
      cyc();
    end
    i_req_i = 1'b0; d_req_i = 1'b0;
    cyc(); cyc();

    // 4: address hold under wait states
    HREADY = 1'b0; i_req_i = 1'b1; i_addr_i = 32'h300; #1;
    chk("t4_a_haddr", HADDR, 32'h300);
    chk("t4_a_gnt", {30'h0, i_gnt_o, d_gnt_o}, 32'h0);
    cyc();
    d_req_i = 1'b1; d_addr_i = 32'h3004; #1;
    chk("t4_b_haddr", HADDR, 32'h300);
    chk("t4_b_hprot", 32'(HPROT), 32'h0);
    chk("t4_b_gnt", {30'h0, i_gnt_o, d_gnt_o}, 32'h0);
    cyc(); #1;
    chk("t4_c_haddr", HADDR, 32'h300);
    chk("t4_c_htrans", 32'(HTRANS), 32'h2);
    cyc();
    HREADY = 1'b1; #1;
    chk("t4_d_gnt", {30'h0, i_gnt_o, d_gnt_o}, 32'h2);
    chk("t4_d_haddr", HADDR, 32'h300);
    cyc();
    i_req_i = 1'b0; #1;
    chk("t4_e_gnt", {30'h0, i_gnt_o, d_gnt_o}, 32'h1);
    chk("t4_e_irvalid", 32'(i_rvalid_o), 32'h1);
    cyc();
    d_req_i = 1'b0; #1;
    chk("t4_f_drvalid", 32'(d_rvalid_o), 32'h1);
    cyc();

    // 5: ERROR response on D read
    d_req_i = 1'b1; d_addr_i = 32'hDEAD_0000; #1;
    chk("t5_a_dgnt", 32'(d_gnt_o), 32'h1);
    cyc();
    d_req_i = 1'b0; i_req_i = 1'b1; i_addr_i = 32'h500; HREADY = 1'b0; HRESP = 1'b1; #1;
    chk("t5_b_htrans", 32'(HTRANS), 32'h0);
    chk("t5_b_out", {29'h0, i_gnt_o, d_rvalid_o, d_err_o}, 32'h0);
    cyc();
    HREADY = 1'b1; #1;
    chk("t5_c_htrans", 32'(HTRANS), 32'h0);
    chk("t5_c_out", {29'h0, i_gnt_o, d_rvalid_o, d_err_o}, 32'h3);
    cyc();
    HRESP = 1'b0; #1;
    chk("t5_d_igrant", {30'h0, i_gnt_o, d_rvalid_o}, 32'h2);
    chk("t5_d_haddr", HADDR, 32'h500);
    cyc();
    i_req_i = 1'b0; #1;
    chk("t5_e_irvalid", {30'h0, i_rvalid_o, i_err_o}, 32'h2);
    cyc();

    // 6: reset during a stalled D data phase
    d_req_i = 1'b1; d_addr_i = 32'h600; #1;
    chk("t6_a_dgnt", 32'(d_gnt_o), 32'h1);
    cyc();
    d_req_i = 1'b0; HREADY = 1'b0; rst_i = 1'b1; #1;
    chk("t6_b_htrans", 32'(HTRANS), 32'h0);
    cyc();
    rst_i = 1'b0; HREADY = 1'b1; #1;
    chk("t6_c_htrans", 32'(HTRANS), 32'h0);
    chk("t6_c_out", {28'h0, i_gnt_o, d_gnt_o, i_rvalid_o, d_rvalid_o}, 32'h0);
    cyc(); #1;
    chk("t6_d_out", {28'h0, i_gnt_o, d_gnt_o, i_rvalid_o, d_rvalid_o}, 32'h0);
    chk("t6_d_hwdata", HWDATA, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
